// File: rtl/sensor_spi_slave_if.sv
// rtl/sensor_spi_slave_if.sv - SPI pin bundle for the sensor slave; MISO tri-stated here from data/enable
interface sensor_spi_slave_if;
    logic SS_n;
    logic MOSI;
    logic MISO_d;
    logic MISO_oe;
    wire  MISO;

    assign MISO = MISO_oe ? MISO_d : 1'bz;

    modport slave  (input SS_n, input MOSI, output MISO_d, output MISO_oe);
    modport master (output SS_n, output MOSI, input MISO, input MISO_oe);
endinterface

// File: rtl/sensor_spi_slave.sv
// rtl/sensor_spi_slave.sv - SPI mode-0 register slave exposing sensor samples, status and a config bank
module sensor_spi_slave (
    input  logic                SCLK,
    input  logic                rst_n,
    sensor_spi_slave_if.slave   spi,
    input  logic signed [15:0]  ptch_rate,
    input  logic signed [15:0]  az,
    input  logic                sample_vld,
    output logic                clr_tgl,
    output logic [127:0]        cfg
);
    typedef enum logic [1:0] {ST_CMD, ST_DATA0, ST_BURST} frame_state_t;

    frame_state_t state;
    logic [2:0]   bit_cnt;
    logic [6:0]   shift;
    logic         rwn;
    logic [6:0]   addr;
    logic [7:0]   tx;
    logic [7:0]   shadow_p;
    logic [7:0]   shadow_a;
    logic         wr_set;
    logic         wr_clr;
    logic         wr_err;
    logic [7:0]   rd_byte;

    // Frame state is wiped by either reset or deselect.
    wire       frame_rst_n = rst_n & ~spi.SS_n;
    wire       byte_done   = (bit_cnt == 3'd7);
    wire [7:0] rx_byte     = {shift, spi.MOSI};
    wire       cfg_hit     = (addr[6:4] == 3'b001);
    wire       commit      = byte_done && (state != ST_CMD) && !rwn;
    // bit_cnt wraps to 0 only after a completed byte, so this marks the reload edge.
    wire       load        = (bit_cnt == 3'd0) && (state != ST_CMD);

    // wr_err is set on rising edges and cleared on falling edges; two toggles avoid a shared driver.
    assign wr_err = wr_set ^ wr_clr;

    assign spi.MISO_d  = tx[7];
    assign spi.MISO_oe = ~spi.SS_n;

    always_ff @(posedge SCLK or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state   <= ST_CMD;
            bit_cnt <= 3'd0;
            shift   <= 7'd0;
            rwn     <= 1'b0;
            addr    <= 7'd0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= {shift[5:0], spi.MOSI};
            if (byte_done) begin
                case (state)
                    ST_CMD: begin
                        rwn   <= rx_byte[7];
                        addr  <= rx_byte[6:0];
                        state <= ST_DATA0;
                    end
                    ST_DATA0: begin
                        addr  <= addr + 7'd1;
                        state <= ST_BURST;
                    end
                    default: addr <= addr + 7'd1;
                endcase
            end
        end
    end

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            cfg    <= '0;
            wr_set <= 1'b0;
        end else if (commit) begin
            if (cfg_hit)
                cfg[{addr[3:0], 3'b000} +: 8] <= rx_byte;
            else if (!wr_err)
                wr_set <= ~wr_set;
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (addr)
            7'h0E:   rd_byte = {6'b0, wr_err, sample_vld};
            7'h0F:   rd_byte = 8'h6A;
            7'h22:   rd_byte = ptch_rate[7:0];
            7'h23:   rd_byte = shadow_p;
            7'h2C:   rd_byte = az[7:0];
            7'h2D:   rd_byte = shadow_a;
            default: if (cfg_hit) rd_byte = cfg[{addr[3:0], 3'b000} +: 8];
        endcase
    end

    always_ff @(negedge SCLK or negedge frame_rst_n) begin
        if (!frame_rst_n)
            tx <= 8'h00;
        else if (load)
            tx <= rwn ? rd_byte : 8'hA5;
        else
            tx <= {tx[6:0], 1'b0};
    end

    // Loading a low byte freezes its high byte so a burst reads a coherent sample.
    always_ff @(negedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            shadow_p <= 8'h00;
            shadow_a <= 8'h00;
            clr_tgl  <= 1'b0;
            wr_clr   <= 1'b0;
        end else if (load && rwn) begin
            case (addr)
                7'h22: begin
                    shadow_p <= ptch_rate[15:8];
                    clr_tgl  <= ~clr_tgl;
                end
                7'h2C:   shadow_a <= az[15:8];
                7'h0E:   if (wr_err) wr_clr <= ~wr_clr;
                default: ;
            endcase
        end
    end
endmodule
